// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: captures 16-bit L/R samples into a one-deep pending
// buffer and serialises them as Philips I2S (16-bit slots, 32 sclk per frame).
module audio_i2s_tx #(
    parameter int SCLK_DIV = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_ce,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    input  logic        mute,
    input  logic        flag_clr,
    output logic        sclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        overflow,
    output logic        underflow
);

    localparam int            CW       = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [4:0]    k;
    logic [4:0]    k_new;
    logic [4:0]    k_lead;
    logic [31:0]   shifter;
    logic [31:0]   last_frame;
    logic [31:0]   pending;
    logic [31:0]   frame;
    logic          pend_valid;
    logic          term;
    logic          fall;
    logic          load;

    always_comb begin
        term   = (cnt == CNT_LAST);
        fall   = term & sclk;
        k_new  = k + 5'd1;
        k_lead = k + 5'd2;
        load   = fall && (k_new == 5'd0);
        // Starved frames repeat the previous frame; mute only blanks the wire.
        frame  = mute ? 32'd0 : (pend_valid ? pending : last_frame);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (term) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

    // Data side moves on the falling sclk edge; lrclk leads data by one bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k       <= 5'd31;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
            shifter <= '0;
        end else if (fall) begin
            k     <= k_new;
            lrclk <= k_lead[4];
            if (load) begin
                sdata   <= frame[31];
                shifter <= {frame[30:0], 1'b0};
            end else begin
                sdata   <= shifter[31];
                shifter <= {shifter[30:0], 1'b0};
            end
        end
    end

    // A load in the same cycle as a capture consumes the old pending value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending    <= '0;
            pend_valid <= 1'b0;
            last_frame <= '0;
        end else begin
            if (sample_ce)
                pending <= {in_l, in_r};
            pend_valid <= sample_ce | (pend_valid & ~load);
            if (load && pend_valid)
                last_frame <= pending;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (sample_ce && pend_valid && !load)
                overflow <= 1'b1;
            else if (flag_clr)
                overflow <= 1'b0;
            if (load && !pend_valid)
                underflow <= 1'b1;
            else if (flag_clr)
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: a timeline model predicts every output per clk edge,
// and a bit receiver collects whole frames for literal checks.
module tb_audio_i2s_tx;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_ce = 1'b0;
    logic [15:0] in_l = '0;
    logic [15:0] in_r = '0;
    logic        mute = 1'b0;
    logic        flag_clr = 1'b0;
    logic        sclk, lrclk, sdata, overflow, underflow;

    int total = 0;
    int bad = 0;

    // Model state: n = clk edges since reset release.
    int          n = 0;
    logic        m_pv = 1'b0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_last = '0;
    logic [31:0] m_cur = '0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic [31:0] rx = '0;
    logic [31:0] rx_frames[$];

    audio_i2s_tx #(.SCLK_DIV(D)) dut (
        .clk(clk), .reset_n(reset_n), .sample_ce(sample_ce), .in_l(in_l),
        .in_r(in_r), .mute(mute), .flag_clr(flag_clr), .sclk(sclk),
        .lrclk(lrclk), .sdata(sdata), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (n=%0d)", name, act, exp, n);
        end
    endtask

    // Frame f is loaded at the fall at edge 2D*(32f+1); sclk toggles every D edges.
    initial begin : model
        logic s_rst, s_ce, s_mute, s_clr;
        logic [31:0] s_in;
        logic ld, e_sclk, e_lr, e_sd;
        int m, kk;
        forever begin
            @(posedge clk);
            s_rst = reset_n; s_ce = sample_ce; s_mute = mute; s_clr = flag_clr;
            s_in = {in_l, in_r};
            #1;
            if (!s_rst) begin
                n = 0; m_pv = 0; m_pend = 0; m_last = 0; m_cur = 0;
                m_ovf = 0; m_unf = 0; rx = 0;
            end else begin
                n++;
                m = n / (2 * D);
                ld = (n % (2 * D) == 0) && ((m - 1) % 32 == 0);
                if (ld && !m_pv) m_unf = 1;
                else if (s_clr) m_unf = 0;
                if (s_ce && m_pv && !ld) m_ovf = 1;
                else if (s_clr) m_ovf = 0;
                if (ld) begin
                    m_cur = s_mute ? 32'd0 : (m_pv ? m_pend : m_last);
                    if (m_pv) m_last = m_pend;
                end
                if (s_ce) begin m_pv = 1; m_pend = s_in; end
                else if (ld) m_pv = 0;
            end
            m = n / (2 * D);
            kk = (m == 0) ? 0 : (m - 1) % 32;
            e_sclk = ((n / D) % 2) == 1;
            e_lr   = (m != 0) && ((m % 32) >= 16);
            e_sd   = (m != 0) && m_cur[31 - kk];
            chk("sclk", 32'(sclk), 32'(e_sclk));
            chk("lrclk", 32'(lrclk), 32'(e_lr));
            chk("sdata", 32'(sdata), 32'(e_sd));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
            // Receiver: sample on the rising sclk edge.
            if (s_rst && m >= 1 && (n % (2 * D) == D)) begin
                rx = {rx[30:0], sdata};
                if (kk == 31) rx_frames.push_back(rx);
            end
        end
    end

    task automatic goto(input int t);
        int g = 0;
        while (n < t && g < 20000) begin @(negedge clk); g++; end
        if (n < t) begin
            total++; bad++;
            $display("FAIL goto: reached n=%0d required n=%0d", n, t);
        end
    endtask

    task automatic send(input int e, input logic [15:0] l, input logic [15:0] r);
        goto(e - 1);
        sample_ce = 1; in_l = l; in_r = r;
        @(negedge clk);
        sample_ce = 0;
    endtask

    task automatic clr_at(input int e);
        goto(e - 1);
        flag_clr = 1;
        @(negedge clk);
        flag_clr = 0;
    endtask

    initial begin : stim
        logic [31:0] exp_frames [11];
        exp_frames = '{32'h0, 32'hA5C3_0F0F, 32'h3333_4444, 32'h8000_7FFF,
                       32'h8000_7FFF, 32'h8000_7FFF, 32'hAAAA_BBBB, 32'hCCCC_DDDD,
                       32'h0, 32'h1234_5678, 32'h5A5A_C3C3};
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_lrclk", 32'(lrclk), 32'd0);
        chk("rst_sdata", 32'(sdata), 32'd0);
        chk("rst_flags", 32'({overflow, underflow}), 32'd0);
        reset_n = 1;
        goto(9);
        chk("first_underflow", 32'(underflow), 32'd1);
        send(100, 16'hA5C3, 16'h0F0F);
        goto(300);
        chk("single_no_ovf", 32'(overflow), 32'd0);
        send(300, 16'h1111, 16'h2222);
        send(310, 16'h3333, 16'h4444);
        goto(320);
        chk("double_ovf", 32'(overflow), 32'd1);
        clr_at(330);
        goto(340);
        chk("clr_flags", 32'({overflow, underflow}), 32'd0);
        send(600, 16'h8000, 16'h7FFF);
        goto(1040);
        chk("starve_unf", 32'(underflow), 32'd1);
        clr_at(1100);
        goto(1200);
        chk("unf_cleared", 32'(underflow), 32'd0);
        goto(1300);
        chk("unf_again", 32'(underflow), 32'd1);
        send(1400, 16'hAAAA, 16'hBBBB);
        send(1544, 16'hCCCC, 16'hDDDD);
        goto(1560);
        chk("coincident_no_ovf", 32'(overflow), 32'd0);
        send(1900, 16'h1234, 16'h5678);
        goto(1949);
        mute = 1;
        goto(2100);
        mute = 0;
        goto(2692);
        chk("pre_rst_sclk", 32'(sclk), 32'd1);
        chk("pre_rst_lrclk", 32'(lrclk), 32'd1);
        #2 reset_n = 0;
        #1;
        chk("async_sclk", 32'(sclk), 32'd0);
        chk("async_lrclk", 32'(lrclk), 32'd0);
        chk("async_sdata", 32'(sdata), 32'd0);
        chk("async_flags", 32'({overflow, underflow}), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1;
        send(4, 16'h5A5A, 16'hC3C3);
        goto(272);
        chk("nframes", 32'(rx_frames.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < rx_frames.size())
                chk($sformatf("frame%0d", i), rx_frames[i], exp_frames[i]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Stereo I2S serializer placed directly downstream of the IIR audio filter.
- Accepts the filter's 16-bit signed L/R output on each sample_ce strobe and holds it in a one-deep pending buffer.
- Generates the bit clock (sclk), word select (lrclk) and serial data (sdata) for an external DAC, in Philips I2S format with 16 bits per slot and 32 sclk per frame.
- Reports sample overflow and underflow through sticky flags.

Parameters:
- SCLK_DIV, 8, clk cycles per sclk half-period (integer ≥2). Frame period is 64*SCLK_DIV clk cycles.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_ce  in  1  one-clk strobe; in_l/in_r are valid in this cycle
- in_l  in  16  left sample, signed
- in_r  in  16  right sample, signed
- mute  in  1  when high, frames loaded into the shifter are all zeros
- flag_clr  in  1  clears the sticky flags
- sclk  out  1  I2S bit clock
- lrclk  out  1  word select: 0 = left, 1 = right
- sdata  out  1  serial data, MSB first
- overflow  out  1  sticky: a pending sample was overwritten before it was loaded
- underflow  out  1  sticky: a frame started with no pending sample

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n). While reset_n=0, all state clears:
  - sclk=0, lrclk=0, sdata=0, overflow=0, underflow=0
  - div counter=0, slot index k=31
  - shifter=0, last frame=0, pending=0, pend_valid=0
- Divider:
  - cnt counts 0..SCLK_DIV-1; at terminal count sclk toggles and cnt returns to 0.
  - "fall" is the clk cycle where sclk goes 1→0; "rise" is 0→1.
  - All data-side outputs update on the same clk edge as fall. The receiver samples on rise.
- Slot counter:
  - k increments on every fall and wraps 31→0.
  - After reset, the first fall gives k=0.
- lrclk:
  - On each fall, lrclk <= bit4 of ((k_new+1) mod 32), so lrclk leads the data by one bit.
  - k_new=31 → lrclk=0; k_new=15 → lrclk=1.
- sdata:
  - On each fall, sdata <= shifter MSB, and the shifter shifts left by one.
  - At k_new=0, the shifter loads the new 32-bit frame {L,R} and sdata <= L[15] in the same edge.
  - Result: k=0..15 carry L[15..0]; k=16..31 carry R[15..0].
- Frame load at k_new=0:
  - If pend_valid=1: frame = pending, last frame <= pending, pend_valid <= 0.
  - If pend_valid=0: frame = last frame, and underflow <= 1.
  - mute=1 forces a zero frame. The pending/last/underflow bookkeeping is unchanged.
  - mute is sampled only at load, so a mid-frame change takes effect from the next frame.
- Capture:
  - On sample_ce, pending <= {in_l,in_r} and pend_valid <= 1.
  - If pend_valid was already 1 and no load happens in that cycle, overflow <= 1.
- Simultaneous sample_ce and load in one cycle:
  - The load uses the old pending.
  - The new sample becomes pending; pend_valid ends at 1.
  - No overflow is flagged.
  - If pend_valid was 0, the load repeats last frame, sets underflow, and the new sample is captured.
- Flags:
  - flag_clr clears both flags.
  - A set event in the same cycle as flag_clr wins: the flag ends at 1.
- Timing:
  - Latency from sample_ce to its first sdata bit is ≤ one frame (64*SCLK_DIV clk) plus one half-period.
  - sample_ce faster than the frame rate causes overflow; slower causes underflow with the last frame repeated.
- Reset mid-frame: all outputs go immediately to their reset values. After release, the first fall starts a fresh frame at k=0 and loads a zero or pending frame as described above.

Test Plan:
- Reset release, SCLK_DIV=4, no samples → sclk period 8 clk; lrclk low for 16 sclk then high for 16; sdata=0; underflow=1 after the first fall.
- One sample_ce with in_l=16'hA5C3, in_r=16'h0F0F, issued before k=0 → sdata sampled on rises gives A5C3 then 0F0F MSB first; lrclk falls one sclk before A5C3 bit15; overflow=0.
- Two sample_ce 10 clk apart (1111/2222, then 3333/4444) before the same load → overflow=1; the frame sent is 3333/4444.
- Samples 8000/7FFF sent once, then no further sample_ce → the next two frames repeat 8000/7FFF; underflow=1; flag_clr pulse → underflow=0 until the next starved load.
- sample_ce coincident with the k_new=0 load cycle (pending=AAAA/BBBB, new=CCCC/DDDD) → current frame is AAAA/BBBB; next frame is CCCC/DDDD; overflow=0.
- mute=1 raised mid-frame with pending 1234/5678 → the current frame completes unchanged; the next frame is all zeros; pend_valid clears; reset_n pulse mid-frame → sclk/lrclk/sdata=0 asynchronously.
